// File: rtl/serial_transmitter_if.sv
// Parallel-load / serial-out port bundle for serial_transmitter.
// The master side is the microprocessor bus; the slave side is the transmitter.
interface serial_transmitter_if;
    logic [7:0] data_in;
    logic       load;
    logic       transmit_enable;
    logic       data_out;
    logic       character_sent;
    logic       busy;
    logic       buffer_full;

    modport master (
        output data_in, load, transmit_enable,
        input  data_out, character_sent, busy, buffer_full
    );

    modport slave (
        input  data_in, load, transmit_enable,
        output data_out, character_sent, busy, buffer_full
    );
endinterface

// File: rtl/serial_transmitter.sv
// Buffered serial transmitter: 10-bit frames (start 0, 8 data LSB-first, stop 1),
// each bit held BIT_TICKS clocks, with back-to-back chaining from a holding buffer.
module serial_transmitter #(
    parameter int unsigned BIT_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_transmitter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e     state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] buf_q, buf_d;
    logic       full_q, full_d;
    logic       data_out_q, data_out_d;
    logic       sent_q, sent_d;
    logic       busy_q, busy_d;
    logic       last_tick;
    logic       transfer;

    assign last_tick = (tick_q == 8'(BIT_TICKS - 1));
    assign transfer  = full_q && bus.transmit_enable &&
                       ((state_q == IDLE) || ((state_q == STOP) && last_tick));

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        full_d     = full_q;
        data_out_d = data_out_q;
        sent_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tick_d     = '0;
                bit_d      = '0;
                data_out_d = 1'b1;
            end
            START: begin
                if (last_tick) begin
                    tick_d     = '0;
                    state_d    = DATA;
                    data_out_d = shift_q[0];
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            DATA: begin
                if (last_tick) begin
                    tick_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d      = '0;
                        state_d    = STOP;
                        data_out_d = 1'b1;
                    end else begin
                        // Shift now so the next bit to drive always sits at shift_q[0].
                        bit_d      = bit_q + 3'd1;
                        shift_d    = {1'b0, shift_q[7:1]};
                        data_out_d = shift_q[1];
                    end
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            STOP: begin
                if (last_tick) begin
                    tick_d     = '0;
                    sent_d     = 1'b1;
                    state_d    = IDLE;
                    data_out_d = 1'b1;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer overrides the STOP->IDLE exit so frames chain with no idle gap.
        if (transfer) begin
            state_d    = START;
            tick_d     = '0;
            bit_d      = '0;
            shift_d    = buf_q;
            data_out_d = 1'b0;
            full_d     = 1'b0;
        end

        if (bus.load) begin
            buf_d  = bus.data_in;
            full_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            full_q     <= 1'b0;
            data_out_q <= 1'b1;
            sent_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            data_out_q <= data_out_d;
            sent_q     <= sent_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.character_sent = sent_q;
    assign bus.busy           = busy_q;
    assign bus.buffer_full    = full_q;
endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 16: clk cycles per serial bit; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; asynchronous and active-high.
REQ-004 SHALL have port data_in, input, 8: parallel character from the microprocessor data bus.
REQ-005 SHALL have port load, input, 1: capture data_in into the holding buffer.
REQ-006 SHALL have port transmit_enable, input, 1: permission to start new frames.
REQ-007 SHALL have port data_out, output, 1: serial line to the receiver's data_in.
REQ-008 SHALL have port character_sent, output, 1: one-cycle pulse at frame completion.
REQ-009 SHALL have port busy, output, 1: high while a frame is on the line (states START, DATA, STOP).
REQ-010 SHALL have port buffer_full, output, 1: holding buffer holds an unsent character.

Function
REQ-011 SHALL transmit 10-bit frames: start bit 0, 8 data bits LSB-first, stop bit 1; idle line level 1.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-013 SHALL hold each bit on data_out for exactly BIT_TICKS clk cycles, using a tick counter 0..BIT_TICKS-1.
REQ-014 SHALL use a 3-bit bit index 0..7 in DATA; DATA is left after index 7 completes its BIT_TICKS.
REQ-015 SHALL, on load=1, write data_in to the holding buffer and set buffer_full on the next edge.
REQ-016 SHALL, when load=1 while buffer_full=1 and no transfer occurs, overwrite the buffer (latest wins); buffer_full stays 1.
REQ-017 SHALL define transfer as: buffer_full=1 AND transmit_enable=1 AND FSM in IDLE, or FSM on the last tick of STOP.
REQ-018 SHALL, on transfer, copy the buffer into the shift register, clear buffer_full, and enter START on the same edge; data_out=0 from the following cycle.
REQ-019 SHALL, on simultaneous load and transfer, send the old buffer contents and capture new data_in, leaving buffer_full=1.
REQ-020 SHALL chain frames back-to-back with no idle cycle when a transfer occurs at the end of STOP; an n-frame burst occupies exactly 10*n*BIT_TICKS cycles.
REQ-021 SHALL, when STOP ends without a transfer, return to IDLE with data_out=1.
REQ-022 SHALL pulse character_sent high for exactly one cycle, in the first cycle after the last STOP tick, for every completed frame, including back-to-back frames.
REQ-023 SHALL complete a frame already in progress if transmit_enable falls mid-frame; it blocks only the next transfer.
REQ-024 SHALL drive data_out from a register (glitch-free; no combinational path from inputs).
REQ-025 SHALL ignore changes on data_in except on cycles where load=1.

Reset
REQ-026 SHALL, while rst=1, force FSM=IDLE, data_out=1, character_sent=0, busy=0, buffer_full=0, tick and bit counters=0, buffer and shift register=8'h00.
REQ-027 SHALL, on rst asserted mid-frame, abort the frame immediately (asynchronously) with data_out=1 and no character_sent pulse.
REQ-028 SHALL start no frame on the first edge after rst falls unless load and transmit_enable are then applied.

Verification
REQ-029 SHALL verify single frame: BIT_TICKS=4, load data_in=8'hA5 for 1 cycle with transmit_enable=1 -> data_out sequence 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; character_sent pulses once at cycle 40 after START entry.
REQ-030 SHALL verify back-to-back: load 8'h3C, start; load 8'hC3 during frame 1 -> frame 2 starts immediately after frame 1 stop; 80 contiguous cycles; two character_sent pulses 40 cycles apart.
REQ-031 SHALL verify gating: transmit_enable=0, load 8'h55 -> buffer_full=1, data_out=1 indefinitely; raise enable -> frame starts next cycle.
REQ-032 SHALL verify overwrite: enable=0, load 8'h11 then 8'h22, enable=1 -> only 8'h22 transmitted, one character_sent pulse.
REQ-033 SHALL verify reset mid-frame: assert rst during DATA bit 3 -> data_out=1, busy=0, buffer_full=0 at once; no character_sent pulse; a subsequent load of 8'hF0 transmits correctly.
REQ-034 SHALL verify loopback: data_out fed to the team's receiver -> received data_out matches each sent character for 8'h00, 8'hFF, 8'hA5.
